// File: rtl/memory_responder.sv
// Single-outstanding memory responder: IDLE/WAIT/RESP FSM with a fixed access
// latency, byte-enabled stores and a registered response held until accepted.
module memory_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                        write;
    logic [31:0]                 addr;
    logic [NUM_LANES-1:0][7:0]   wdata;
    logic [NUM_LANES-1:0]        be;
  } req_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  req_t                      req_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;
  logic [NUM_LANES-1:0][7:0] rd_word;
  logic                      accept, access, req_err;
  logic [IDX_W-1:0]          idx;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign access    = (state_q == WAIT) && (cnt_q == 4'd0);
  assign req_err   = (req_q.addr[1:0] != 2'b00) ||
                     ({2'b00, req_q.addr[31:2]} >= 32'(DEPTH_WORDS));
  assign idx       = req_q.addr[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY);
      end
      WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage is split into byte lanes so each enable gates its own array.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    always_ff @(posedge clk)
      if (access && req_q.write && !req_err && req_q.be[g])
        lane_mem[idx] <= req_q.wdata[g];
    assign rd_word[g] = lane_mem[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) req_q <= '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};
      if (access) begin
        err_q   <= req_err;
        rdata_q <= (req_q.write || req_err) ? '0 : rd_word;
      end
    end
  end

  // Response registers may hold stale data outside RESP; mask them here.
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_error = rsp_valid & err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder against a word-array reference model,
// plus directed cases for byte enables, errors, backpressure, reset and LATENCY=0.
module tb_memory_responder;
  localparam int DW = 32, DEPTH = 256, LAT = 2;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [31:0]   req_addr = 0, req_wdata = 0;
  logic [3:0]    req_be = 0;
  logic          req_ready, rsp_valid, rsp_error;
  logic [31:0]   rsp_rdata;

  logic          z_valid = 0, z_write = 0, z_rsp_ready = 0;
  logic [31:0]   z_addr = 0, z_wdata = 0;
  logic [3:0]    z_be = 0;
  logic          z_ready, z_rsp_valid, z_rsp_error;
  logic [31:0]   z_rdata;

  memory_responder #(.DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error));

  memory_responder #(.DATA_WIDTH(DW), .DEPTH_WORDS(16), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
    .req_write(z_write), .req_addr(z_addr), .req_wdata(z_wdata), .req_be(z_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rdata), .rsp_error(z_rsp_error));

  int n_chk = 0, n_pass = 0;
  logic [31:0] mdl [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  // Present a request; once accepted keep req_valid high with a junk store
  // so a responder that wrongly accepts while busy corrupts the model check.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1;
    chk("req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_write = 1; req_addr = 0; req_wdata = '1; req_be = '1;
  endtask

  task automatic await_rsp(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er);
    logic [31:0] rd_e;
    logic        er_e;
    int          idx, edges;
    er_e = is_err(a);
    rd_e = 0;
    idx  = int'(a >> 2);
    if (!er_e) begin
      if (w) begin
        for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      end else rd_e = mdl[idx];
    end
    send(w, a, d, be);
    await_rsp(edges);
    chk("latency", edges, LAT + 1);
    repeat (hold) begin
      chk("hold", {rsp_valid, req_ready, rsp_error, rsp_rdata}, {1'b1, 1'b0, er_e, rd_e});
      @(posedge clk); #1;
    end
    chk("rsp", {rsp_valid, req_ready, rsp_error, rsp_rdata}, {1'b1, 1'b0, er_e, rd_e});
    rd = rsp_rdata; er = rsp_error;
    @(negedge clk) rsp_ready = 1;
    @(posedge clk); #1;
    req_valid = 0; rsp_ready = 0;
    chk("done", {rsp_valid, req_ready, rsp_error, rsp_rdata}, {1'b1 ^ 1'b1, 1'b1, 1'b0, 32'h0});
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        er;
    int          kind, edges;
    int          acc[$], rsp[$];

    #12;
    chk("reset", {rsp_valid, req_ready, rsp_error, rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("ready_after_rst", req_ready, 1);

    for (int i = 0; i < DEPTH; i++) do_req(1, 32'(i * 4), $urandom, 4'hF, 0, rd, er);

    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    chk("st_rdata", rd, 0);
    chk("st_err", er, 0);

    do_req(1, 32'h20, 32'h11223344, 4'hF, 0, rd, er);
    do_req(1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd, er);
    do_req(0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("be_merge", rd, 32'h11BB33DD);

    do_req(0, 32'h22, 32'h0, 4'hF, 0, rd, er);
    chk("misalign", {er, rd}, {1'b1, 32'h0});
    do_req(1, 32'(DEPTH * 4), 32'h5555AAAA, 4'hF, 0, rd, er);
    chk("oor_store", {er, rd}, {1'b1, 32'h0});
    do_req(0, 32'(DEPTH * 4), 32'h0, 4'hF, 0, rd, er);
    chk("oor_load", {er, rd}, {1'b1, 32'h0});
    do_req(1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er);
    chk("be0_err", er, 0);
    do_req(0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("after_err", rd, 32'h11BB33DD);

    do_req(0, 32'h10, 32'h0, 4'h0, 5, rd, er);
    chk("bp_data", rd, 32'hDEADBEEF);

    // Reset during WAIT must drop the pending store.
    do_req(1, 32'h30, 32'h0, 4'hF, 0, rd, er);
    send(1, 32'h30, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #2;
    rst = 0; #1;
    chk("rst_wait", {rsp_valid, req_ready, rsp_error, rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});
    req_valid = 0;
    @(negedge clk) rst = 1;
    do_req(0, 32'h30, 32'h0, 4'h0, 0, rd, er);
    chk("rst_no_store", rd, 32'h0);

    // Reset during RESP discards the response.
    send(0, 32'h10, 32'h0, 4'h0);
    await_rsp(edges);
    chk("pre_rst_resp", rsp_valid, 1);
    @(negedge clk) rst = 0; #1;
    chk("rst_resp", {rsp_valid, req_ready, rsp_error, rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});
    req_valid = 0;
    @(negedge clk) rst = 1;
    do_req(0, 32'h10, 32'h0, 4'h0, 0, rd, er);

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
      else if (kind == 1) a = 32'(DEPTH * 4) + ($urandom & 32'h00FF_FFFC);
      else if (kind < 6)  a = $urandom_range(0, 15) << 2;
      else                a = $urandom_range(0, DEPTH - 1) << 2;
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), rd, er);
    end

    // LATENCY=0 with request and response handshakes held open.
    @(negedge clk);
    z_write = 1; z_addr = 32'h4; z_wdata = 32'h5; z_be = 4'hF;
    z_valid = 1; z_rsp_ready = 1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (z_ready) acc.push_back(i);
      if (z_rsp_valid) begin
        rsp.push_back(i);
        chk("l0_err", z_rsp_error, 0);
      end
    end
    @(negedge clk) z_valid = 0;
    chk("l0_acc_cnt", acc.size(), 10);
    chk("l0_rsp_cnt", rsp.size(), 10);
    for (int k = 0; k + 1 < acc.size(); k++) chk("l0_gap", acc[k+1] - acc[k], 3);
    for (int k = 0; k < acc.size() && k < rsp.size(); k++) chk("l0_rsp_lat", rsp[k] - acc[k], 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data word width, equal to REGISTER_WIDTH from common.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of storage words.
REQ-003 SHALL have parameter LATENCY, default 2, range 0..15, meaning the wait cycles between request acceptance and the storage access.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  store data.
REQ-011 SHALL have port req_be  input  DATA_WIDTH/8  store byte enables.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-014 SHALL have port rsp_rdata  output  DATA_WIDTH  load data.
REQ-015 SHALL have port rsp_error  output  1  the request was rejected.

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, WAIT and RESP, and SHALL support at most one outstanding request.
REQ-017 SHALL drive req_ready=1 only in IDLE, combinationally from the state.
REQ-018 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, capture write, addr, wdata and be, load wait_cnt with LATENCY, and enter WAIT.
REQ-019 SHALL, in WAIT with wait_cnt>0, decrement wait_cnt each edge.
REQ-020 SHALL, in WAIT with wait_cnt=0, perform the storage access on the next edge and enter RESP.
REQ-021 SHALL therefore assert rsp_valid exactly LATENCY+1 edges after the accepting edge.
REQ-022 SHALL treat a request as an error when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
REQ-023 SHALL, on a valid store, write only the bytes whose req_be bit is 1, and return rsp_rdata=0 and rsp_error=0.
REQ-024 SHALL, on a valid load, return the full word stored at addr[31:2], ignoring req_be, with rsp_error=0.
REQ-025 SHALL, on an error request, leave storage unmodified and return rsp_rdata=0 and rsp_error=1.
REQ-026 SHALL treat a store with req_be=0 as valid: no bytes change, and rsp_error=0.
REQ-027 SHALL, in RESP, hold rsp_valid, rsp_rdata and rsp_error stable until an edge where rsp_ready=1, then return to IDLE.
REQ-028 SHALL not overlap response completion and acceptance: req_ready is 0 during the RESP cycle, so a new request is accepted no earlier than the cycle after the response completes.
REQ-029 SHALL ignore req_* inputs outside IDLE, and SHALL ignore rsp_ready outside RESP.
REQ-030 SHALL drive rsp_valid=0 in IDLE and WAIT, and SHALL drive rsp_rdata and rsp_error to 0 whenever rsp_valid=0.
REQ-031 SHALL evaluate the access against storage contents as they stand at the access edge, so a load returns the data of every store completed before it.

Reset
REQ-032 SHALL, while rst=0, force the state to IDLE, wait_cnt=0, rsp_valid=0, rsp_rdata=0 and rsp_error=0, independent of clk.
REQ-033 SHALL drive req_ready=1 on the first edge after rst is released.
REQ-034 SHALL not reset storage contents.
REQ-035 SHALL, when reset is asserted in WAIT before the access edge, drop the request and commit no store.
REQ-036 SHALL, when reset is asserted in RESP, discard the pending response.

Verification
REQ-037 Test: LATENCY=2; store addr=0x10, wdata=0xDEADBEEF, be=0xF; rsp_ready=1 -> rsp_valid 3 edges after acceptance, rsp_error=0, rsp_rdata=0.
REQ-038 Test: store 0x11223344 to 0x20 with be=0xF, then store 0xAABBCCDD to 0x20 with be=0x5, then load 0x20 -> rsp_rdata=0x11BB33DD.
REQ-039 Test: load addr=0x22 and load addr=DEPTH_WORDS*4 -> both rsp_error=1 and rsp_rdata=0; a following load at 0x20 is unchanged.
REQ-040 Test: response backpressure, rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_error stable throughout, req_ready=0, and exactly one transfer when rsp_ready rises.
REQ-041 Test: store 0x0 to 0x30 completed; store 0xFFFFFFFF to 0x30 accepted, then rst pulsed low in WAIT -> outputs cleared asynchronously, and a subsequent load of 0x30 returns 0x00000000.
REQ-042 Test: LATENCY=0 with req_valid held high and rsp_ready=1 -> back-to-back requests each complete in 3 cycles (accept, access, respond).
